// File: rtl/game_ctl.sv
// game_ctl: air hockey match sequencer.
// Runs the round flow IDLE -> SERVE -> PLAY -> GOAL/OVER. It gates the ball
// controller through ball_hold/ball_run and owns both player scores. Frame
// timing comes from vsync rising edges.
//
// Handshake: there is no valid/ready pair here. goal_p1/goal_p2 are single-cycle
// strobes that are only acted on in PLAY. start is an asynchronous level; only
// its synchronized rising edge matters, and only in IDLE or OVER.
module game_ctl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned GOAL_FRAMES  = 120
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       vsync_in,
  input  logic       start,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       ball_hold,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] player_1_score,
  output logic [3:0] player_2_score,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GOAL  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [3:0] WIN4       = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] GOAL_LAST  = 8'(GOAL_FRAMES - 1);

  // start synchronizer (s1, s2) plus edge-detect history (s3)
  logic start_s1, start_s2, start_s3;
  logic start_p;
  // vsync history and registered frame tick
  logic vsync_q, tick_q;

  logic [7:0] cnt, cnt_nxt;
  logic [2:0] state_nxt;
  logic [3:0] p1_nxt, p2_nxt;
  logic [3:0] p1_inc, p2_inc;
  logic       dir_nxt, winner_nxt;

  assign start_p = start_s2 & ~start_s3;
  assign p1_inc  = 4'(player_1_score + 4'd1);
  assign p2_inc  = 4'(player_2_score + 4'd1);

  // Input conditioning: start synchronizer/edge detector and frame tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      vsync_q  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      vsync_q  <= vsync_in;
      tick_q   <= vsync_in & ~vsync_q;
    end
  end

  // State register together with the frame counter, scores, serve direction and winner.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= 8'd0;
      player_1_score <= 4'd0;
      player_2_score <= 4'd0;
      serve_dir      <= 1'b0;
      winner         <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      player_1_score <= p1_nxt;
      player_2_score <= p2_nxt;
      serve_dir      <= dir_nxt;
      winner         <= winner_nxt;
    end
  end

  // Next-state logic: round flow, frame counting and scoring.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    p1_nxt     = player_1_score;
    p2_nxt     = player_2_score;
    dir_nxt    = serve_dir;
    winner_nxt = winner;
    case (state)
      S_IDLE: begin
        if (start_p) begin
          state_nxt = S_SERVE;
          p1_nxt    = 4'd0;
          p2_nxt    = 4'd0;
          dir_nxt   = 1'b0;
        end
      end
      S_SERVE: begin
        if (tick_q) begin
          if (cnt == SERVE_LAST) state_nxt = S_PLAY;
          else                   cnt_nxt   = 8'(cnt + 8'd1);
        end
      end
      S_PLAY: begin
        // goal_p1 takes priority when both strobes arrive together
        if (goal_p1) begin
          p1_nxt  = p1_inc;
          dir_nxt = 1'b1;
          if (p1_inc == WIN4) begin
            state_nxt  = S_OVER;
            winner_nxt = 1'b0;
          end else begin
            state_nxt = S_GOAL;
          end
        end else if (goal_p2) begin
          p2_nxt  = p2_inc;
          dir_nxt = 1'b0;
          if (p2_inc == WIN4) begin
            state_nxt  = S_OVER;
            winner_nxt = 1'b1;
          end else begin
            state_nxt = S_GOAL;
          end
        end
      end
      S_GOAL: begin
        if (tick_q) begin
          if (cnt == GOAL_LAST) state_nxt = S_SERVE;
          else                  cnt_nxt   = 8'(cnt + 8'd1);
        end
      end
      S_OVER: begin
        if (start_p) begin
          state_nxt  = S_SERVE;
          p1_nxt     = 4'd0;
          p2_nxt     = 4'd0;
          dir_nxt    = 1'b0;
          winner_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // every state entry starts the frame count from zero
    if (state_nxt != state) cnt_nxt = 8'd0;
  end

  // Output decode from the registered state.
  always_comb begin
    ball_hold = (state != S_PLAY);
    ball_run  = (state == S_PLAY);
    game_over = (state == S_OVER);
  end

endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: randomized bench for game_ctl against a frame/round-level model.
module tb_game_ctl;

  localparam int WIN = 2;
  localparam int SRV = 3;
  localparam int GL  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_GOAL  = 3;
  localparam int P_OVER  = 4;

  // clock / reset
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst_n;
  logic       vsync_in, start, goal_p1, goal_p2;
  logic       ball_hold, ball_run, serve_dir, game_over, winner;
  logic [3:0] player_1_score, player_2_score;
  logic [2:0] state;

  game_ctl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SRV), .GOAL_FRAMES(GL)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .vsync_in(vsync_in), .start(start),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .ball_hold(ball_hold),
    .ball_run(ball_run), .serve_dir(serve_dir), .player_1_score(player_1_score),
    .player_2_score(player_2_score), .game_over(game_over), .winner(winner),
    .state(state)
  );

  int errors = 0;
  int checks = 0;

  // scoreboard-style single comparison point
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: round phase, frames still to wait, scores
  int m_phase, m_left, m_p1, m_p2, m_dir, m_win;
  bit start_hist[$];
  bit vs_hist[$];

  task automatic model_reset();
    m_phase = P_IDLE; m_left = 0; m_p1 = 0; m_p2 = 0; m_dir = 0; m_win = 0;
    start_hist = {1'b0, 1'b0, 1'b0, 1'b0};
    vs_hist    = {1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  // one clock edge of the match rules, given the inputs sampled at that edge
  task automatic model_step(input bit st, input bit vs, input bit g1, input bit g2);
    bit start_edge, frame;
    start_hist.push_front(st);
    void'(start_hist.pop_back());
    vs_hist.push_front(vs);
    void'(vs_hist.pop_back());
    // start seen two edges ago as a rising level; vsync rise seen one edge ago
    start_edge = start_hist[2] & ~start_hist[3];
    frame      = vs_hist[1] & ~vs_hist[2];
    case (m_phase)
      P_IDLE, P_OVER: begin
        if (start_edge) begin
          m_phase = P_SERVE; m_left = SRV;
          m_p1 = 0; m_p2 = 0; m_dir = 0; m_win = 0;
        end
      end
      P_SERVE: begin
        if (frame) begin
          m_left--;
          if (m_left == 0) m_phase = P_PLAY;
        end
      end
      P_PLAY: begin
        if (g1) begin
          m_p1++; m_dir = 1;
          if (m_p1 == WIN) begin m_phase = P_OVER; m_win = 0; end
          else begin m_phase = P_GOAL; m_left = GL; end
        end else if (g2) begin
          m_p2++; m_dir = 0;
          if (m_p2 == WIN) begin m_phase = P_OVER; m_win = 1; end
          else begin m_phase = P_GOAL; m_left = GL; end
        end
      end
      P_GOAL: begin
        if (frame) begin
          m_left--;
          if (m_left == 0) begin m_phase = P_SERVE; m_left = SRV; end
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_all(input string pfx);
    check_eq({pfx, ".state"},     8'(state),          8'(m_phase));
    check_eq({pfx, ".ball_hold"}, 8'(ball_hold),      8'(m_phase != P_PLAY));
    check_eq({pfx, ".ball_run"},  8'(ball_run),       8'(m_phase == P_PLAY));
    check_eq({pfx, ".game_over"}, 8'(game_over),      8'(m_phase == P_OVER));
    check_eq({pfx, ".serve_dir"}, 8'(serve_dir),      8'(m_dir));
    check_eq({pfx, ".p1_score"},  8'(player_1_score), 8'(m_p1));
    check_eq({pfx, ".p2_score"},  8'(player_2_score), 8'(m_p2));
    check_eq({pfx, ".winner"},    8'(winner),         8'(m_win));
  endtask

  // vsync generator state: half-period countdown
  int vs_left = 4;

  task automatic drive_vsync();
    vs_left--;
    if (vs_left <= 0) begin
      vsync_in = ~vsync_in;
      vs_left  = $urandom_range(3, 6);
    end
  endtask

  // one cycle: drive, clock, advance model, check
  task automatic run_cycle(input bit use_start, input bit use_goals, input string pfx);
    drive_vsync();
    if (use_start && $urandom_range(0, 24) == 0) start = ~start;
    if (use_goals) begin
      goal_p1 = ($urandom_range(0, 9) == 0);
      goal_p2 = ($urandom_range(0, 9) == 0);
    end else begin
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
    end
    @(posedge clk_in);
    if (rst_n) model_step(start, vsync_in, goal_p1, goal_p2);
    #1;
    check_all(pfx);
  endtask

  int resets_done = 0;

  initial begin
    rst_n = 1'b0; vsync_in = 1'b0; start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
    model_reset();

    // held in reset: stray start and goal pulses have no effect
    repeat (2) @(posedge clk_in);
    #2 start = 1'b1; goal_p1 = 1'b1;
    @(posedge clk_in); #1;
    goal_p1 = 1'b0;
    check_all("in_reset");
    @(posedge clk_in); #1;
    start = 1'b0;
    check_eq("in_reset.state_const", 8'(state), 8'd0);
    check_eq("in_reset.hold_const",  8'(ball_hold), 8'd1);
    repeat (2) @(posedge clk_in);
    #2 rst_n = 1'b1;

    // no start after release: stays idle across several frames
    for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b1, "idle_hold");

    // randomized match play
    for (int i = 0; i < 4000; i++) begin
      run_cycle(1'b1, 1'b1, "rand");
      if (i > 800 && resets_done < 3 && m_phase == P_GOAL && $urandom_range(0, 3) == 0) begin
        // asynchronous reset in the middle of a goal pause
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check_eq("async_rst.state_const", 8'(state), 8'd0);
        repeat (2) begin
          @(posedge clk_in); #1;
          check_all("rst_hold");
        end
        rst_n = 1'b1;
        resets_done++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
